// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with combinational outputs and a
// one-cycle registered copy qualified by a valid pulse.
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic [WIDTH-1:0] sum_r_o,
   output logic             carry_r_o,
   output logic             overflow_r_o,
   output logic             valid_r_o
);
   logic [WIDTH:0]   cy;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             carry_d, carry_q, overflow_d, overflow_q, valid_d, valid_q;
   assign cy[0] = c_i;
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign s[i]    = a_i[i] ^ b_i[i] ^ cy[i];
      assign cy[i+1] = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
   end
   assign sum_o      = s;
   assign carry_o    = cy[WIDTH];
   // Signed overflow: carry into the MSB disagrees with carry out of it.
   assign overflow_o = cy[WIDTH] ^ cy[WIDTH-1];
   always_comb begin
      sum_d      = en_i ? s : sum_q;
      carry_d    = en_i ? cy[WIDTH] : carry_q;
      overflow_d = en_i ? cy[WIDTH] ^ cy[WIDTH-1] : overflow_q;
      valid_d    = en_i;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sum_q      <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         sum_q      <= sum_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
      end
   end
   assign sum_r_o      = sum_q;
   assign carry_r_o    = carry_q;
   assign overflow_r_o = overflow_q;
   assign valid_r_o    = valid_q;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed checks of full_adder at WIDTH 1/8/16/32
// against an arithmetic reference model.
module tb_full_adder;
   logic clk = 1'b0;
   logic rst, en;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic [0:0]  a1, b1, s1, sr1;
   logic        c1, co1, ov1, cr1, ovr1, v1;
   logic [7:0]  a8, b8, s8, sr8;
   logic        c8, co8, ov8, cr8, ovr8, v8;
   logic [15:0] a16, b16, s16, sr16;
   logic        c16, co16, ov16, cr16, ovr16, v16;
   logic [31:0] a32, b32, s32, sr32;
   logic        c32, co32, ov32, cr32, ovr32, v32;

   full_adder #(.WIDTH(1)) u1 (
      .clk_i(clk), .rst_i(rst), .a_i(a1), .b_i(b1), .c_i(c1), .en_i(en),
      .sum_o(s1), .carry_o(co1), .overflow_o(ov1),
      .sum_r_o(sr1), .carry_r_o(cr1), .overflow_r_o(ovr1), .valid_r_o(v1));
   full_adder #(.WIDTH(8)) u8 (
      .clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8), .c_i(c8), .en_i(en),
      .sum_o(s8), .carry_o(co8), .overflow_o(ov8),
      .sum_r_o(sr8), .carry_r_o(cr8), .overflow_r_o(ovr8), .valid_r_o(v8));
   full_adder #(.WIDTH(16)) u16 (
      .clk_i(clk), .rst_i(rst), .a_i(a16), .b_i(b16), .c_i(c16), .en_i(en),
      .sum_o(s16), .carry_o(co16), .overflow_o(ov16),
      .sum_r_o(sr16), .carry_r_o(cr16), .overflow_r_o(ovr16), .valid_r_o(v16));
   full_adder #(.WIDTH(32)) u32 (
      .clk_i(clk), .rst_i(rst), .a_i(a32), .b_i(b32), .c_i(c32), .en_i(en),
      .sum_o(s32), .carry_o(co32), .overflow_o(ov32),
      .sum_r_o(sr32), .carry_r_o(cr32), .overflow_r_o(ovr32), .valid_r_o(v32));

   // Reference: overflow means the true signed sum falls outside the w-bit range.
   function automatic logic ref_ovf(input longint a, input longint b, input longint c, input int w);
      longint m, sa, sb, t;
      m  = longint'(1) <<< (w - 1);
      sa = (a >= m) ? a - 2 * m : a;
      sb = (b >= m) ? b - 2 * m : b;
      t  = sa + sb + c;
      return (t >= m) || (t < -m);
   endfunction

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      a1 = '0; b1 = '0; c1 = 0; a8 = '0; b8 = '0; c8 = 0;
      a16 = '0; b16 = '0; c16 = 0; a32 = '0; b32 = '0; c32 = 0;
      #12;
      checks++;
      if ({sr1, cr1, ovr1, v1} !== 4'b0) begin
         errors++; $display("FAIL reset_w1 got %b want 0000", {sr1, cr1, ovr1, v1});
      end
      checks++;
      if ({sr8, cr8, ovr8, v8} !== 11'b0) begin
         errors++; $display("FAIL reset_w8 got %h want 0", {sr8, cr8, ovr8, v8});
      end
      checks++;
      if ({sr16, cr16, ovr16, v16} !== 19'b0 || {sr32, cr32, ovr32, v32} !== 35'b0) begin
         errors++; $display("FAIL reset_w16_w32 got %h %h want 0 0", {sr16, cr16, ovr16, v16}, {sr32, cr32, ovr32, v32});
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_truth_table();
      logic [7:0] ts, tc;
      ts = 8'b1001_0110;
      tc = 8'b1110_1000;
      for (int i = 0; i < 8; i++) begin
         {a1, b1, c1} = 3'(i);
         #5;
         checks++;
         if (s1 !== ts[i] || co1 !== tc[i]) begin
            errors++; $display("FAIL truth_%0d got s=%b c=%b want s=%b c=%b", i, s1, co1, ts[i], tc[i]);
         end
         #5;
      end
   endtask

   task automatic test_wrap_overflow();
      a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1; #5;
      checks++;
      if (s16 !== 16'h0000 || co16 !== 1'b1 || ov16 !== 1'b0) begin
         errors++; $display("FAIL wrap got %h/%b/%b want 0000/1/0", s16, co16, ov16);
      end
      #5; a16 = 16'h7FFF; b16 = 16'h0001; c16 = 1'b0; #5;
      checks++;
      if (s16 !== 16'h8000 || co16 !== 1'b0 || ov16 !== 1'b1) begin
         errors++; $display("FAIL pos_ovf got %h/%b/%b want 8000/0/1", s16, co16, ov16);
      end
      #5; a16 = 16'h8000; b16 = 16'h8000; c16 = 1'b0; #5;
      checks++;
      if (s16 !== 16'h0000 || co16 !== 1'b1 || ov16 !== 1'b1) begin
         errors++; $display("FAIL neg_ovf got %h/%b/%b want 0000/1/1", s16, co16, ov16);
      end
      #5;
   endtask

   task automatic test_registered();
      @(negedge clk) begin a8 = 8'h12; b8 = 8'h34; c8 = 1'b1; en = 1'b1; end
      @(posedge clk) #1;
      checks++;
      if (sr8 !== 8'h47 || cr8 !== 1'b0 || ovr8 !== 1'b0 || v8 !== 1'b1) begin
         errors++; $display("FAIL reg_capture got %h/%b/%b v=%b want 47/0/0 v=1", sr8, cr8, ovr8, v8);
      end
      en = 1'b0; a8 = 8'hF0; b8 = 8'hF0;
      @(posedge clk) #1;
      checks++;
      if (sr8 !== 8'h47 || v8 !== 1'b0) begin
         errors++; $display("FAIL reg_hold got %h v=%b want 47 v=0", sr8, v8);
      end
   endtask

   task automatic test_back_to_back();
      longint t;
      logic   eo;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk) begin a32 = $urandom; b32 = $urandom; c32 = 1'($urandom); en = 1'b1; end
         t  = longint'(a32) + longint'(b32) + longint'(c32);
         eo = ref_ovf(longint'(a32), longint'(b32), longint'(c32), 32);
         @(posedge clk) #1;
         checks++;
         if ({cr32, sr32} !== t[32:0] || ovr32 !== eo || v32 !== 1'b1) begin
            errors++; $display("FAIL b2b_%0d got %h ov=%b v=%b want %h ov=%b v=1", k, {cr32, sr32}, ovr32, v32, t[32:0], eo);
         end
      end
      @(negedge clk) begin en = 1'b0; a32 = ~a32; end
      @(posedge clk) #1;
      checks++;
      if ({cr32, sr32} !== t[32:0] || v32 !== 1'b0) begin
         errors++; $display("FAIL b2b_hold got %h v=%b want %h v=0", {cr32, sr32}, v32, t[32:0]);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk) begin a8 = 8'hC3; b8 = 8'h5A; c8 = 1'b0; en = 1'b1; end
      @(posedge clk) #1;
      checks++;
      if ({cr8, sr8} !== 9'h11D || v8 !== 1'b1) begin
         errors++; $display("FAIL ar_capture got %h v=%b want 11d v=1", {cr8, sr8}, v8);
      end
      @(negedge clk) en = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({sr8, cr8, ovr8, v8} !== 11'b0 || {sr32, cr32, ovr32} !== 34'b0) begin
         errors++; $display("FAIL ar_immediate got %h %h want 0 0", {sr8, cr8, ovr8, v8}, {sr32, cr32, ovr32});
      end
      a8 = 8'h80; b8 = 8'h7F; c8 = 1'b1; #1;
      checks++;
      if ({co8, s8} !== 9'h100 || ov8 !== 1'b0) begin
         errors++; $display("FAIL ar_comb got %h ov=%b want 100 ov=0", {co8, s8}, ov8);
      end
      en = 1'b1;
      @(posedge clk) #1;
      checks++;
      if ({sr8, cr8, ovr8, v8} !== 11'b0) begin
         errors++; $display("FAIL ar_edge_in_reset got %h want 0", {sr8, cr8, ovr8, v8});
      end
      @(negedge clk) begin rst = 1'b0; a8 = 8'h40; b8 = 8'h40; c8 = 1'b0; end
      @(posedge clk) #1;
      checks++;
      if ({cr8, sr8} !== 9'h080 || ovr8 !== 1'b1 || v8 !== 1'b1) begin
         errors++; $display("FAIL ar_first_capture got %h ov=%b v=%b want 080 ov=1 v=1", {cr8, sr8}, ovr8, v8);
      end
      en = 1'b0;
   endtask

   task automatic test_random();
      longint t;
      for (int i = 0; i < 1000; i++) begin
         a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
         a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
         #2;
         t = longint'(a1) + longint'(b1) + longint'(c1);
         checks++;
         if ({co1, s1} !== t[1:0] || ov1 !== ref_ovf(longint'(a1), longint'(b1), longint'(c1), 1)) begin
            errors++; $display("FAIL rand_w1 %0d a=%b b=%b c=%b got %b ov=%b want %b", i, a1, b1, c1, {co1, s1}, ov1, t[1:0]);
         end
         t = longint'(a8) + longint'(b8) + longint'(c8);
         checks++;
         if ({co8, s8} !== t[8:0] || ov8 !== ref_ovf(longint'(a8), longint'(b8), longint'(c8), 8)) begin
            errors++; $display("FAIL rand_w8 %0d a=%h b=%h c=%b got %h ov=%b want %h", i, a8, b8, c8, {co8, s8}, ov8, t[8:0]);
         end
         t = longint'(a32) + longint'(b32) + longint'(c32);
         checks++;
         if ({co32, s32} !== t[32:0] || ov32 !== ref_ovf(longint'(a32), longint'(b32), longint'(c32), 32)) begin
            errors++; $display("FAIL rand_w32 %0d a=%h b=%h c=%b got %h ov=%b want %h", i, a32, b32, c32, {co32, s32}, ov32, t[32:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_truth_table();
      test_wrap_overflow();
      test_registered();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
